board_ctrl: RTL

Game-state controller for the tic-tac-toe display pipeline. It turns mouse clicks into moves on a 3x3 board, alternates X/O turns, and detects win or draw. The resulting board configuration is published to the drawing stages only at vertical blanking, so no frame ever shows a half-updated board. It sits beside the draw_* pipeline; its display outputs drive the board/mark drawing stages.

---
 rtl/board_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe game-state controller.
// Turns mouse clicks into moves on a 3x3 board, alternates X/O, detects a
// win or a draw, and publishes board/turn/winner to the drawing stages only
// on the rising edge of vertical blanking.
// Optional build macro: MOUSE_SYNC_EN adds a 2-stage register synchronizer
// on the mouse inputs (adds 2 cycles of click-to-board latency).
module board_ctrl #(
    parameter int BOARD_X   = 212,
    parameter int BOARD_Y   = 84,
    parameter int CELL_SIZE = 200
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        restart,
    output logic [17:0] board_disp,
    output logic        turn_disp,
    output logic [1:0]  winner_disp,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_CHECK = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic [17:0] board_disp_q;
    logic        turn_disp_q;
    logic [1:0]  winner_disp_q;
    logic        left_prev_q;
    logic        vblnk_prev_q;

    logic        left_s;
    logic [11:0] x_s;
    logic [11:0] y_s;

`ifdef MOUSE_SYNC_EN
    logic [24:0] sync1_q;
    logic [24:0] sync2_q;

    // Two-stage synchronizer for the mouse button and cursor position
    always_ff @(posedge pclk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {mouse_left, mouse_xpos, mouse_ypos};
            sync2_q <= sync1_q;
        end
    end

    assign {left_s, x_s, y_s} = sync2_q;
`else
    assign left_s = mouse_left;
    assign x_s    = mouse_xpos;
    assign y_s    = mouse_ypos;
`endif

    // Cell decode by range comparison against the three column/row bands
    logic [31:0] x_w;
    logic [31:0] y_w;
    logic [2:0]  col_hit;
    logic [2:0]  row_hit;
    logic [1:0]  cell_w [9];

    assign x_w = {20'd0, x_s};
    assign y_w = {20'd0, y_s};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_band
            assign col_hit[gi] = (x_w >= 32'(BOARD_X + gi * CELL_SIZE)) &&
                                 (x_w <  32'(BOARD_X + (gi + 1) * CELL_SIZE));
            assign row_hit[gi] = (y_w >= 32'(BOARD_Y + gi * CELL_SIZE)) &&
                                 (y_w <  32'(BOARD_Y + (gi + 1) * CELL_SIZE));
        end
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign cell_w[gi] = board_q[2*gi +: 2];
        end
    endgenerate

    function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
    endfunction

    logic [1:0] col_idx;
    logic [1:0] row_idx;
    logic [3:0] cell_idx;
    logic       cell_valid;
    logic       cell_empty;
    logic       click;
    logic [1:0] line_win;
    logic       board_full;

    // Combinational decode of clicked cell, line detection and full-board test
    always_comb begin
        col_idx    = 2'd0;
        row_idx    = 2'd0;
        cell_empty = 1'b0;
        line_win   = 2'b00;
        board_full = 1'b1;
        if (col_hit[1]) col_idx = 2'd1;
        else if (col_hit[2]) col_idx = 2'd2;
        if (row_hit[1]) row_idx = 2'd1;
        else if (row_hit[2]) row_idx = 2'd2;
        cell_valid = (|col_hit) && (|row_hit);
        cell_idx   = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx};
        click      = left_s && !left_prev_q;
        for (int k = 0; k < 9; k++) begin
            if (4'(k) == cell_idx) cell_empty = (cell_w[k] == 2'b00);
            if (cell_w[k] == 2'b00) board_full = 1'b0;
        end
        for (int r = 0; r < 3; r++) begin
            if (line_win == 2'b00) line_win = line3(cell_w[3*r], cell_w[3*r+1], cell_w[3*r+2]);
        end
        for (int c = 0; c < 3; c++) begin
            if (line_win == 2'b00) line_win = line3(cell_w[c], cell_w[c+3], cell_w[c+6]);
        end
        if (line_win == 2'b00) line_win = line3(cell_w[0], cell_w[4], cell_w[8]);
        if (line_win == 2'b00) line_win = line3(cell_w[2], cell_w[4], cell_w[6]);
    end

    // Next-state logic: move entry, one-cycle result check, restart priority
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        if (restart) begin
            board_d  = '0;
            turn_d   = 1'b0;
            winner_d = 2'b00;
            state_d  = S_PLAY;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (click && cell_valid && cell_empty) begin
                        for (int k = 0; k < 9; k++) begin
                            if (4'(k) == cell_idx) board_d[2*k +: 2] = turn_q ? 2'b10 : 2'b01;
                        end
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (line_win != 2'b00) begin
                        winner_d = line_win;
                        state_d  = S_OVER;
                    end else if (board_full) begin
                        winner_d = 2'b11;
                        state_d  = S_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_PLAY;
                    end
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_PLAY;
            endcase
        end
    end

    // Working-copy state registers and input edge history
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= S_PLAY;
            board_q      <= '0;
            turn_q       <= 1'b0;
            winner_q     <= 2'b00;
            left_prev_q  <= 1'b0;
            vblnk_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            left_prev_q  <= left_s;
            vblnk_prev_q <= vblnk_in;
        end
    end

    // Publish the working copy once per frame, on the vblank rising edge
    always_ff @(posedge pclk) begin
        if (rst) begin
            board_disp_q  <= '0;
            turn_disp_q   <= 1'b0;
            winner_disp_q <= 2'b00;
        end else if (vblnk_in && !vblnk_prev_q) begin
            board_disp_q  <= board_q;
            turn_disp_q   <= turn_q;
            winner_disp_q <= winner_q;
        end
    end

    assign board_disp  = board_disp_q;
    assign turn_disp   = turn_disp_q;
    assign winner_disp = winner_disp_q;
    assign game_over   = (state_q == S_OVER);

endmodule
